// File: rtl/math_op_sequencer.sv
// Stores a short ALU program and plays it into the accumulator ALU, either one op per cycle or one op per step press.
// All ALU-side outputs are registered; the first alu_en comes the cycle after alu_clr; loads are refused while a run is active.
module math_op_sequencer #(
  parameter int  DEPTH = 8,
  parameter int  OP_W  = 2,
  parameter int  ARG_W = 3,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [OP_W-1:0]  load_op,
  input  logic [ARG_W-1:0] load_arg,
  output logic             load_ready,
  input  logic             clear_prog,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             abort,
  output logic             alu_clr,
  output logic             alu_en,
  output logic [OP_W-1:0]  alu_op,
  output logic [ARG_W-1:0] alu_arg,
  output logic             busy,
  output logic             done,
  output logic [LW-1:0]    prog_len,
  output logic [PW-1:0]    pc
);

  localparam int IW = OP_W + ARG_W;

  typedef enum logic [1:0] {IDLE, CLR, RUN, STEP} state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    mem [DEPTH];
  logic             start_q, step_q, stepm_q;
  logic             start_rise, step_rise, has_prog, go, issue, last, load_fire;
  logic [LW-1:0]    pc_ext;

  logic             clr_nx, en_nx, done_nx;
  logic [OP_W-1:0]  op_nx;
  logic [ARG_W-1:0] arg_nx;
  logic [PW-1:0]    pc_nx;
  logic [LW-1:0]    len_nx;

  assign start_rise = start & ~start_q;
  assign step_rise  = step & ~step_q;
  assign has_prog   = (prog_len != '0);
  assign go         = (state == IDLE) & start_rise & ~clear_prog;
  assign load_ready = (state == IDLE) & (prog_len < LW'(DEPTH)) & ~start_rise & ~clear_prog;
  assign load_fire  = load_valid & load_ready;
  assign pc_ext     = LW'(pc);
  assign last       = ((pc_ext + LW'(1)) == prog_len);
  assign issue      = ~abort & (((state == CLR) & ~stepm_q) | (state == RUN) |
                                ((state == STEP) & step_rise));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go && has_prog) state_nx = CLR;
      default: begin
        if (abort || (issue && last)) state_nx = IDLE;
        else if (state == CLR)        state_nx = stepm_q ? STEP : RUN;
      end
    endcase
  end

  // Next values for the registered outputs; busy-state guards make start/load/clear inert mid-run.
  always_comb begin
    clr_nx          = go & has_prog;
    en_nx           = issue;
    {op_nx, arg_nx} = issue ? mem[pc] : {alu_op, alu_arg};
    pc_nx           = pc;
    done_nx         = done;
    len_nx          = prog_len;
    if (state == IDLE) begin
      if (clear_prog) begin
        len_nx  = '0;
        done_nx = 1'b0;
      end else if (start_rise) begin
        done_nx = ~has_prog;
        pc_nx   = '0;
      end else if (load_fire) begin
        len_nx  = prog_len + LW'(1);
      end
    end else if (abort) begin
      pc_nx = '0;
    end else if (issue) begin
      pc_nx   = last ? '0 : pc + PW'(1);
      done_nx = last;
    end
  end

  // Button history resets high so a button held through reset release is not an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_q  <= 1'b1;
      step_q   <= 1'b1;
      stepm_q  <= 1'b0;
      alu_clr  <= 1'b0;
      alu_en   <= 1'b0;
      alu_op   <= '0;
      alu_arg  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      prog_len <= '0;
      pc       <= '0;
    end else begin
      start_q  <= start;
      step_q   <= step;
      if (go) stepm_q <= step_mode;
      alu_clr  <= clr_nx;
      alu_en   <= en_nx;
      alu_op   <= op_nx;
      alu_arg  <= arg_nx;
      busy     <= (state_nx != IDLE);
      done     <= done_nx;
      prog_len <= len_nx;
      pc       <= pc_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (load_fire) mem[prog_len[PW-1:0]] <= {load_op, load_arg};
  end

endmodule

// File: tb/tb_math_op_sequencer.sv
// Scoreboard bench: expected issues are queued by the stimulus, a negedge monitor checks every alu_en.
module tb_math_op_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       load_valid, load_ready, clear_prog, start, step_mode, step, abort;
  logic [1:0] load_op, alu_op;
  logic [2:0] load_arg, alu_arg;
  logic       alu_clr, alu_en, busy, done;
  logic [3:0] prog_len;
  logic [2:0] pc;

  int         checks = 0;
  int         failures = 0;
  int         en_cnt = 0;
  int         clr_cnt = 0;
  logic [7:0] acc = '0;
  logic [4:0] exp_q[$];
  logic [4:0] e;

  math_op_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .load_valid(load_valid), .load_op(load_op), .load_arg(load_arg), .load_ready(load_ready),
    .clear_prog(clear_prog), .start(start), .step_mode(step_mode), .step(step), .abort(abort),
    .alu_clr(alu_clr), .alu_en(alu_en), .alu_op(alu_op), .alu_arg(alu_arg),
    .busy(busy), .done(done), .prog_len(prog_len), .pc(pc)
  );

  always #5 clock = ~clock;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clock) begin
    if (reset_n) begin
      if (alu_clr && alu_en) check("clr_en_overlap", alu_en, 0);
      if (alu_clr) begin
        acc = '0;
        clr_cnt++;
      end
      if (alu_en) begin
        en_cnt++;
        if (exp_q.size() == 0) check("en_without_expect", alu_en, 0);
        else begin
          e = exp_q.pop_front();
          check("alu_op", alu_op, e[4:3]);
          check("alu_arg", alu_arg, e[2:0]);
        end
        case (alu_op)
          2'b00: acc = acc + 8'(alu_arg);
          2'b01: acc = acc - 8'(alu_arg);
          2'b10: acc = acc ^ 8'(alu_arg);
          default: acc = acc << alu_arg;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [1:0] op, input logic [2:0] arg);
    load_valid = 1'b1; load_op = op; load_arg = arg;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic press_start(input logic sm);
    step_mode = sm; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear();
    clear_prog = 1'b1;
    tick();
    clear_prog = 1'b0;
  endtask

  task automatic load8();
    for (int i = 0; i < 8; i++) load(2'(i % 4), 3'(7 - i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; load_valid = 0; load_op = 0; load_arg = 0; clear_prog = 0;
    start = 0; step_mode = 0; step = 0; abort = 0;
    #12;
    check("rst_load_ready", load_ready, 1);
    check("rst_alu_en", alu_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prog_len", prog_len, 0);
    check("rst_pc", pc, 0);
    #10 reset_n = 1'b1;
    tick(); tick();

    // 1: three-op run, accumulator 0+3-1<<2 = 8
    load(2'd0, 3'd3); load(2'd1, 3'd1); load(2'd3, 3'd2);
    check("t1_prog_len", prog_len, 3);
    exp_q.push_back({2'd0, 3'd3}); exp_q.push_back({2'd1, 3'd1}); exp_q.push_back({2'd3, 3'd2});
    en_cnt = 0; clr_cnt = 0;
    press_start(1'b0);
    check("t1_clr", alu_clr, 1);
    check("t1_en_in_clr", alu_en, 0);
    check("t1_busy", busy, 1);
    tick(); check("t1_en1", alu_en, 1); check("t1_clr_off", alu_clr, 0);
    tick(); check("t1_en2", alu_en, 1);
    tick(); check("t1_en3", alu_en, 1); check("t1_done", done, 1); check("t1_busy_end", busy, 0);
    tick(); check("t1_en_off", alu_en, 0);
    check("t1_op_hold", alu_op, 3); check("t1_arg_hold", alu_arg, 2);
    check("t1_acc", acc, 8);
    check("t1_clr_cnt", clr_cnt, 1);
    check("t1_q_empty", exp_q.size(), 0);

    // 2: fill 8 slots, 9th load dropped, full run
    clear();
    check("t2_cleared_len", prog_len, 0);
    check("t2_cleared_done", done, 0);
    load8();
    check("t2_ready_full", load_ready, 0);
    load(2'd2, 3'd5);
    check("t2_len_full", prog_len, 8);
    for (int i = 0; i < 8; i++) exp_q.push_back({2'(i % 4), 3'(7 - i)});
    en_cnt = 0;
    press_start(1'b0);
    repeat (12) tick();
    check("t2_en_cnt", en_cnt, 8);
    check("t2_pc", pc, 0);
    check("t2_done", done, 1);
    check("t2_q_empty", exp_q.size(), 0);

    // 4: abort after third issue
    for (int i = 0; i < 3; i++) exp_q.push_back({2'(i % 4), 3'(7 - i)});
    en_cnt = 0;
    press_start(1'b0);
    tick(); tick(); tick();
    check("t4_en3", alu_en, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_busy", busy, 0); check("t4_en", alu_en, 0);
    check("t4_done", done, 0); check("t4_pc", pc, 0);
    repeat (5) tick();
    check("t4_en_cnt", en_cnt, 3);
    check("t4_prog_len", prog_len, 8);

    // 3: single-step, held step gives one issue
    clear();
    load(2'd2, 3'd6); load(2'd1, 3'd2);
    exp_q.push_back({2'd2, 3'd6});
    en_cnt = 0;
    press_start(1'b1);
    tick();
    step = 1'b1;
    repeat (5) tick();
    step = 1'b0;
    tick();
    check("t3_en_cnt1", en_cnt, 1); check("t3_done1", done, 0); check("t3_busy1", busy, 1);
    exp_q.push_back({2'd1, 3'd2});
    step = 1'b1;
    tick();
    step = 1'b0;
    check("t3_en2", alu_en, 1); check("t3_done2", done, 1); check("t3_busy2", busy, 0);
    tick();
    check("t3_en_cnt2", en_cnt, 2);

    // 5: empty program start, clear vs load
    clear();
    clr_cnt = 0; en_cnt = 0;
    press_start(1'b0);
    check("t5_done", done, 1); check("t5_busy", busy, 0); check("t5_clr", alu_clr, 0);
    repeat (3) tick();
    check("t5_clr_cnt", clr_cnt, 0); check("t5_en_cnt", en_cnt, 0);
    load(2'd0, 3'd1);
    clear_prog = 1'b1; load_valid = 1'b1;
    #1 check("t5_ready_clear", load_ready, 0);
    tick();
    clear_prog = 1'b0; load_valid = 1'b0;
    check("t5_len", prog_len, 0);

    // 6: asynchronous reset mid-run, start held through release
    load8();
    for (int i = 0; i < 8; i++) exp_q.push_back({2'(i % 4), 3'(7 - i)});
    en_cnt = 0;
    press_start(1'b0);
    tick(); tick();
    #1 reset_n = 1'b0;
    #1;
    check("t6_en", alu_en, 0); check("t6_busy", busy, 0);
    check("t6_len", prog_len, 0); check("t6_pc", pc, 0);
    exp_q.delete();
    check("t6_en_cnt", en_cnt, 1);
    start = 1'b1;
    #12 reset_n = 1'b1;
    clr_cnt = 0; en_cnt = 0;
    tick();
    load(2'd0, 3'd1); load(2'd0, 3'd2);
    repeat (4) tick();
    check("t6_no_run_busy", busy, 0);
    check("t6_no_run_done", done, 0);
    check("t6_no_run_clr", clr_cnt, 0);
    check("t6_no_run_en", en_cnt, 0);
    start = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
